ram8_burst_ctrl: RTL
====================

Name: ram8_burst_ctrl

Overview:
Initiator for the RAM8 write/read port. It accepts burst commands from upstream and drives RAM8 `in`/`load`/`address`. Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream. It sits between datapath producers/consumers and a RAM8 instance, and adds flow control the bare RAM8 port lacks.

Parameters:
- DATA_W, 16, word width; matches RAM8 `in`/`out`.
- ADDR_W, 3, address width; depth = 2**ADDR_W = 8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  beats minus one (0 means 1 beat, 7 means 8 beats).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  controller accepts write beat.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  consumer accepts read beat.
- rd_data  out  DATA_W  read beat data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after a burst completes.
- ram_in  out  DATA_W  to RAM8 `in`.
- ram_load  out  1  to RAM8 `load`.
- ram_address  out  ADDR_W  to RAM8 `address`.
- ram_out  in  DATA_W  from RAM8 `out` (combinational read of `ram_address`).

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - cmd_ready = 1 once IDLE is reached; wr_ready = 0, rd_valid = 0, rd_data = 0, busy = 0, done = 0.
  - ram_load = 0, ram_in = 0, ram_address = 0.
- Reset mid-burst aborts the burst with no further RAM writes. Already-written RAM contents are untouched and no done pulse is produced.
- Registers: cur_addr (ADDR_W), beats_left (ADDR_W), state, rd_valid, rd_data, done.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: cur_addr <= cmd_addr, beats_left <= cmd_len.
  - Next state is WRITE if cmd_write = 1, else READ.
- WRITE:
  - wr_ready = 1; ram_address = cur_addr; ram_in = wr_data.
  - ram_load = wr_valid (combinational), so RAM8 captures at the same edge as the handshake.
  - Each accepted beat: cur_addr <= cur_addr + 1, modulo 8 (7 wraps to 0).
  - If beats_left == 0 on an accepted beat: next state IDLE, done = 1 in the following cycle. Otherwise beats_left decrements.
  - wr_valid low means a stall: nothing changes and ram_load = 0.
- READ:
  - ram_address = cur_addr; ram_load = 0 in every state except WRITE.
  - When !rd_valid || rd_ready: rd_data <= ram_out, rd_valid <= 1, cur_addr advances (wrapping).
  - If beats_left == 0 at that point: next state DRAIN. Otherwise beats_left decrements.
  - If rd_valid && !rd_ready: rd_data and rd_valid hold stable; no advance.
  - Throughput is 1 beat/cycle while rd_ready stays high. First beat is valid 1 cycle after command acceptance.
- DRAIN:
  - Wait for rd_valid && rd_ready; then rd_valid <= 0, state IDLE, done = 1 next cycle.
- wr_ready = 0 outside WRITE. Write beats offered in other states are ignored (not consumed).
- A command is never accepted while busy. Back-to-back commands: the next one can be accepted in the cycle done pulses.
- Wrap: start 6, len 3 touches addresses 6, 7, 0, 1.

Decomposition:
- Package ram8_ctrl_pkg holds:
  - state enum (IDLE=0, WRITE=1, READ=2, DRAIN=3);
  - DATA_W/ADDR_W defaults;
  - localparam DEPTH.
- One sub-module, ram8_beat_counter: holds cur_addr and beats_left. Inputs load, start, len, step. Outputs addr and last (beats_left == 0). Wraps modulo DEPTH.

Test Plan:
- Reset: assert rst_n=0 mid WRITE burst at beat 2 of 4 -> all outputs 0 and cmd_ready=1 after release; RAM addr 2 = 0x1234 written before reset, address 3 untouched.
- Single write then read: write addr 2 data 0x1234 (len 0) -> ram_load high for exactly 1 cycle with ram_address=2; read addr 2 -> rd_data=0x1234, done pulses once per burst.
- Wrap burst: write addr 6, len 3, data 0xA000..0xA003 -> RAM 6=0xA000, 7=0xA001, 0=0xA002, 1=0xA003; read back identical order.
- Read backpressure: 8-beat read from 0 with rd_ready toggling 1,0,0,1,... -> rd_data stable while stalled, no beat lost or duplicated, exactly 8 handshakes, done after the last one.
- Write stall: wr_valid gapped (1,0,1,0) for len 1 -> ram_load only on valid cycles, 2 RAM writes total; cmd_valid asserted during busy is not accepted until the done cycle.

Source files
------------

// File: rtl/ram8_ctrl_pkg.sv
// Shared definitions for the RAM8 burst controller.
// State encoding, default widths and memory depth.
package ram8_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH      = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/ram8_beat_counter.sv
// Burst address / remaining-beat tracker.
// The address wraps naturally at 2**ADDR_W entries.
module ram8_beat_counter
    import ram8_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] start,
    input  logic [ADDR_W-1:0] len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] left_q, left_d;

    always_comb begin
        addr_d = addr_q;
        left_d = left_q;
        if (load) begin
            addr_d = start;
            left_d = len;
        end else if (step) begin
            addr_d = addr_q + ADDR_W'(1);
            if (left_q != '0) begin
                left_d = left_q - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            left_q <= '0;
        end else begin
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end

    assign addr = addr_q;
    assign last = (left_q == '0);

endmodule

// File: rtl/ram8_burst_ctrl.sv
// Burst initiator for a RAM8 port with valid/ready
// write and read streams.
module ram8_burst_ctrl
    import ram8_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    state_e            state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              done_q, done_d;

    logic              accept;
    logic              wr_fire;
    logic              rd_adv;
    logic              drain_fire;
    logic              step;
    logic              last;
    logic [ADDR_W-1:0] cur_addr;

    assign accept     = (state_q == IDLE) && cmd_valid;
    assign wr_fire    = (state_q == WRITE) && wr_valid;
    assign rd_adv     = (state_q == READ) && (!rd_valid_q || rd_ready);
    assign drain_fire = (state_q == DRAIN) && rd_valid_q && rd_ready;
    assign step       = wr_fire || rd_adv;

    ram8_beat_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .start (cmd_addr),
        .len   (cmd_len),
        .step  (step),
        .addr  (cur_addr),
        .last  (last)
    );

    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_fire && last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            READ: begin
                if (rd_adv) begin
                    rd_data_d  = ram_out;
                    rd_valid_d = 1'b1;
                    if (last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Final beat stays presented until the consumer takes it.
                if (drain_fire) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign wr_ready    = (state_q == WRITE);
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign done        = done_q;
    assign ram_load    = wr_fire;
    assign ram_in      = (state_q == WRITE) ? wr_data : '0;
    assign ram_address = ((state_q == WRITE) || (state_q == READ)) ? cur_addr : '0;

endmodule
